// File: rtl/ex_pkg.sv
// Purpose: shared encodings for the execute stage (alu_op, funct, ALU select, mul/div FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ex_pkg;

   // alu_op field from the main decoder
   localparam logic [2:0] ALU_OP_ADD   = 3'b000;
   localparam logic [2:0] ALU_OP_SUB   = 3'b001;
   localparam logic [2:0] ALU_OP_RTYPE = 3'b010;
   localparam logic [2:0] ALU_OP_ANDI  = 3'b011;
   localparam logic [2:0] ALU_OP_ORI   = 3'b100;
   localparam logic [2:0] ALU_OP_XORI  = 3'b101;
   localparam logic [2:0] ALU_OP_SLTI  = 3'b110;
   localparam logic [2:0] ALU_OP_SLTIU = 3'b111;

   // R-type function field
   localparam logic [5:0] F_SLL   = 6'h00;
   localparam logic [5:0] F_SRL   = 6'h02;
   localparam logic [5:0] F_SRA   = 6'h03;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_ADDU  = 6'h21;
   localparam logic [5:0] F_SUB   = 6'h22;
   localparam logic [5:0] F_SUBU  = 6'h23;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_XOR   = 6'h26;
   localparam logic [5:0] F_NOR   = 6'h27;
   localparam logic [5:0] F_SLT   = 6'h2A;
   localparam logic [5:0] F_SLTU  = 6'h2B;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_HI, ALU_LO, ALU_ZERO
   } alu_sel_e;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_RUN,
      MD_FIX
   } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Purpose: iterative multiply/divide engine owning the architectural HI/LO registers.
// Latency: accept in cycle 0, XLEN RUN cycles, one FIX cycle; HI/LO valid from cycle XLEN+2.
// Backpressure: start is taken only in IDLE; busy is high for the whole RUN/FIX window.
// Ports: clk, rst_n (sync, active-low), start, op (bit1 = divide, bit0 = unsigned), a (rs), b (rt),
//        busy, hi, lo.
module muldiv_iter
   import ex_pkg::*;
#(
   parameter  int XLEN = 32,
   localparam int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   md_state_e       state, state_nxt;
   logic [SHW-1:0]  count;
   logic [XLEN-1:0] acc_hi;      // product high half / partial remainder
   logic [XLEN-1:0] acc_lo;      // multiplier / dividend, shifted out as quotient bits shift in
   logic [XLEN-1:0] opnd_b;      // |multiplicand| or |divisor|
   logic [XLEN-1:0] orig_a;      // raw rs, returned in HI on divide by zero
   logic            is_div, neg_lo, neg_hi, div_zero;

   logic            sgn, neg_a, neg_b;
   logic [XLEN-1:0] mag_a, mag_b;
   logic [XLEN:0]   mul_sum, div_shift, div_diff;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0] fix_hi, fix_lo;

   always_comb begin
      sgn   = ~op[0];
      neg_a = sgn & a[XLEN-1];
      neg_b = sgn & b[XLEN-1];
      mag_a = neg_a ? -a : a;
      mag_b = neg_b ? -b : b;

      // one shift-add step: add multiplicand when the current multiplier bit is set, shift right
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
      // one restoring step: bring the next dividend bit into the remainder and trial-subtract
      div_shift = {acc_hi, acc_lo[XLEN-1]};
      div_diff  = div_shift - {1'b0, opnd_b};

      // sign correction; INT_MIN / -1 falls out naturally as 2^(XLEN-1) negated
      prod   = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      fix_hi = prod[2*XLEN-1:XLEN];
      fix_lo = prod[XLEN-1:0];
      if (is_div) begin
         if (div_zero) begin
            fix_hi = orig_a;
            fix_lo = '1;
         end else begin
            fix_hi = neg_hi ? -acc_hi : acc_hi;
            fix_lo = neg_lo ? -acc_lo : acc_lo;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MD_IDLE: if (start) state_nxt = MD_RUN;
         MD_RUN:  if (count == SHW'(XLEN-1)) state_nxt = MD_FIX;
         MD_FIX:  state_nxt = MD_IDLE;
         default: state_nxt = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= MD_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count    <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opnd_b   <= '0;
         orig_a   <= '0;
         is_div   <= 1'b0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (start) begin
                  count    <= '0;
                  acc_hi   <= '0;
                  acc_lo   <= mag_a;
                  opnd_b   <= mag_b;
                  orig_a   <= a;
                  is_div   <= op[1];
                  neg_lo   <= neg_a ^ neg_b;   // product sign, or quotient sign
                  neg_hi   <= neg_a;           // remainder follows the dividend
                  div_zero <= (b == '0);
               end
            end
            MD_RUN: begin
               count <= count + SHW'(1);
               if (is_div) begin
                  acc_hi <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                  acc_lo <= {acc_lo[XLEN-2:0], ~div_diff[XLEN]};
               end else begin
                  acc_hi <= mul_sum[XLEN:1];
                  acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
               end
            end
            MD_FIX: begin
               hi <= fix_hi;
               lo <= fix_lo;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != MD_IDLE);

endmodule

// File: rtl/ex_muldiv_unit.sv
// Purpose: EX stage - operand forwarding, ALU, and the mul/div engine with HI/LO.
// Latency: ALU/forwarding combinational; mul/div results in HI/LO XLEN+2 cycles after accept.
// Backpressure: md_stall holds the front of the pipe while an MD op or mfhi/mflo meets a busy engine.
// Ports: forward_a/b select rs/rt source; read_data_1/2, ex_mem_alu_result, mem_wb_write_data, imm_ext
//        are operand sources; funct/shamt/alu_op/alu_src/ex_valid decode; alu_result, write_data,
//        md_stall, md_busy out.
module ex_muldiv_unit
   import ex_pkg::*;
#(
   parameter  int XLEN = 32,
   localparam int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      forward_a,
   input  logic [1:0]      forward_b,
   input  logic [XLEN-1:0] read_data_1,
   input  logic [XLEN-1:0] read_data_2,
   input  logic [XLEN-1:0] ex_mem_alu_result,
   input  logic [XLEN-1:0] mem_wb_write_data,
   input  logic [XLEN-1:0] imm_ext,
   input  logic [5:0]      funct,
   input  logic [SHW-1:0]  shamt,
   input  logic [2:0]      alu_op,
   input  logic            alu_src,
   input  logic            ex_valid,
   output logic [XLEN-1:0] alu_result,
   output logic [XLEN-1:0] write_data,
   output logic            md_stall,
   output logic            md_busy
);

   logic [XLEN-1:0] op_a, b_fwd, op_b;
   logic [XLEN-1:0] md_hi, md_lo;
   alu_sel_e        alu_sel;
   logic            is_md, is_mf;

   always_comb begin
      case (forward_a)
         2'b10:   op_a = ex_mem_alu_result;
         2'b01:   op_a = mem_wb_write_data;
         default: op_a = read_data_1;
      endcase
      case (forward_b)
         2'b10:   b_fwd = ex_mem_alu_result;
         2'b01:   b_fwd = mem_wb_write_data;
         default: b_fwd = read_data_2;
      endcase
      op_b = alu_src ? imm_ext : b_fwd;
   end

   always_comb begin
      alu_sel = ALU_ADD;
      is_md   = 1'b0;
      is_mf   = 1'b0;
      case (alu_op)
         ALU_OP_ADD:   alu_sel = ALU_ADD;
         ALU_OP_SUB:   alu_sel = ALU_SUB;
         ALU_OP_ANDI:  alu_sel = ALU_AND;
         ALU_OP_ORI:   alu_sel = ALU_OR;
         ALU_OP_XORI:  alu_sel = ALU_XOR;
         ALU_OP_SLTI:  alu_sel = ALU_SLT;
         ALU_OP_SLTIU: alu_sel = ALU_SLTU;
         ALU_OP_RTYPE: begin
            case (funct)
               F_ADD, F_ADDU: alu_sel = ALU_ADD;
               F_SUB, F_SUBU: alu_sel = ALU_SUB;
               F_AND:  alu_sel = ALU_AND;
               F_OR:   alu_sel = ALU_OR;
               F_XOR:  alu_sel = ALU_XOR;
               F_NOR:  alu_sel = ALU_NOR;
               F_SLT:  alu_sel = ALU_SLT;
               F_SLTU: alu_sel = ALU_SLTU;
               F_SLL:  alu_sel = ALU_SLL;
               F_SRL:  alu_sel = ALU_SRL;
               F_SRA:  alu_sel = ALU_SRA;
               F_MFHI: begin alu_sel = ALU_HI; is_mf = 1'b1; end
               F_MFLO: begin alu_sel = ALU_LO; is_mf = 1'b1; end
               F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                  alu_sel = ALU_ZERO;
                  is_md   = 1'b1;
               end
               default: alu_sel = ALU_ADD;
            endcase
         end
         default: alu_sel = ALU_ADD;
      endcase
   end

   // shifts take rt (b_fwd), never the immediate
   always_comb begin
      alu_result = '0;
      case (alu_sel)
         ALU_ADD:  alu_result = op_a + op_b;
         ALU_SUB:  alu_result = op_a - op_b;
         ALU_AND:  alu_result = op_a & op_b;
         ALU_OR:   alu_result = op_a | op_b;
         ALU_XOR:  alu_result = op_a ^ op_b;
         ALU_NOR:  alu_result = ~(op_a | op_b);
         ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         ALU_SLL:  alu_result = b_fwd << shamt;
         ALU_SRL:  alu_result = b_fwd >> shamt;
         ALU_SRA:  alu_result = $signed(b_fwd) >>> shamt;
         ALU_HI:   alu_result = md_hi;
         ALU_LO:   alu_result = md_lo;
         default:  alu_result = '0;
      endcase
   end

   assign write_data = b_fwd;

   // funct[1:0] of mult/multu/div/divu already encodes {divide, unsigned}
   muldiv_iter #(.XLEN(XLEN)) u_muldiv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (ex_valid & is_md),
      .op    (funct[1:0]),
      .a     (op_a),
      .b     (b_fwd),
      .busy  (md_busy),
      .hi    (md_hi),
      .lo    (md_lo)
   );

   // only instructions that touch HI/LO wait for the engine; everything else flows past it
   assign md_stall = rst_n & ex_valid & md_busy & (is_md | is_mf);

endmodule
